// File: rtl/matrix_subtraction_seq.sv
// Sequential ROWSxCOLS matrix subtractor: C = A - B, one element per clock.
// Operands are captured on start. Results and per-element borrow flags are
// published together with a one-cycle done pulse.
module matrix_subtraction_seq #(
  parameter int unsigned ELEM_W = 4,
  parameter int unsigned ROWS   = 2,
  parameter int unsigned COLS   = 2,
  // Derived; not meant to be overridden
  localparam int unsigned N     = ROWS * COLS,
  localparam int unsigned BUS_W = N * ELEM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [0:BUS_W-1] A,
  input  logic [0:BUS_W-1] B,
  output logic [0:BUS_W-1] C,
  output logic [0:N-1]     borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCompute,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [0:BUS_W-1] a_q, a_d;
  logic [0:BUS_W-1] b_q, b_d;
  // Scratch results, hidden from the outputs until the operation completes
  logic [0:BUS_W-1] diff_q, diff_d;
  logic [0:N-1]     brw_q, brw_d;
  logic [0:BUS_W-1] c_q, c_d;
  logic [0:N-1]     borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [ELEM_W-1:0] elem_a, elem_b;
  logic [ELEM_W:0]   elem_sub;

  // Select the current element and subtract with one extra bit to expose the borrow
  always_comb begin
    elem_a   = a_q[int'(cnt_q) * ELEM_W +: ELEM_W];
    elem_b   = b_q[int'(cnt_q) * ELEM_W +: ELEM_W];
    elem_sub = {1'b0, elem_a} - {1'b0, elem_b};
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    brw_d    = brw_q;
    c_d      = c_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCompute;
        end
      end
      StCompute: begin
        diff_d[int'(cnt_q) * ELEM_W +: ELEM_W] = elem_sub[ELEM_W-1:0];
        brw_d[int'(cnt_q)]                     = elem_sub[ELEM_W];
        if (cnt_q == LastIdx) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        c_d      = diff_q;
        borrow_d = brw_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and data registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      brw_q    <= '0;
      c_q      <= '0;
      borrow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      brw_q    <= brw_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    C      = c_q;
    borrow = borrow_q;
    busy   = busy_q;
    done   = done_q;
  end

endmodule

// File: tb/tb_matrix_subtraction_seq.sv
// Directed testbench for matrix_subtraction_seq with hand-computed expectations.
module tb_matrix_subtraction_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [0:15] A;
  logic [0:15] B;
  logic [0:15] C;
  logic [0:3]  borrow;
  logic        busy;
  logic        done;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  matrix_subtraction_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .C      (C),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation: start pulse, wait for done with a bound, check result
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_c, input logic [3:0] exp_b);
    logic [15:0] prev_c;
    int lat;
    prev_c = C;
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, busy, 1);
    lat = 0;
    while (!done && lat < 10) begin
      tick();
      lat++;
      if (!done) begin
        check({tag, " busy mid"}, busy, 1);
        check({tag, " C stable mid"}, C, prev_c);
      end
    end
    check({tag, " latency"}, lat, 5);
    check({tag, " C"}, C, exp_c);
    check({tag, " borrow"}, borrow, exp_b);
    check({tag, " busy at done"}, busy, 0);
    tick();
    check({tag, " done one cycle"}, done, 0);
    check({tag, " C held"}, C, exp_c);
  endtask

  initial begin
    int dones;
    int last;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset C", C, 0);
    check("reset borrow", borrow, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);

    run_op("basic", 16'h9876, 16'h1234, 16'h8642, 4'b0000);
    run_op("underflow", 16'h0000, 16'h1111, 16'hFFFF, 4'b1111);
    run_op("mixed", 16'h3A05, 16'h5106, 16'hE90F, 4'b1001);
    run_op("equal", 16'h7C3A, 16'h7C3A, 16'h0000, 4'b0000);
    run_op("zero minus max", 16'h0000, 16'hFFFF, 16'h1111, 4'b1111);

    // Operand isolation and start while busy
    A = 16'hFFFF;
    B = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    A = 16'h0000;
    dones = 0;
    for (int i = 1; i <= 14; i++) begin
      start = (i == 2) ? 1'b1 : 1'b0;
      tick();
      if (done) begin
        dones++;
        check("isolation done edge", i, 5);
        check("isolation C", C, 16'hFFFF);
        check("isolation borrow", borrow, 0);
      end
    end
    start = 1'b0;
    check("isolation single done", dones, 1);
    run_op("fresh start", 16'h3A05, 16'h5106, 16'hE90F, 4'b1001);

    // Reset mid-operation
    A = 16'h1234;
    B = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("async rst C", C, 0);
    check("async rst borrow", borrow, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("no done after abort", dones, 0);
    check("C after abort", C, 0);
    run_op("after reset", 16'h5555, 16'h1111, 16'h4444, 4'b0000);

    // Back-to-back with start held high
    A = 16'h8888;
    B = 16'h0101;
    start = 1'b1;
    tick();
    dones = 0;
    last = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (done) begin
        dones++;
        if (dones == 1) check("b2b first done", i, 5);
        else check("b2b period", i - last, 6);
        last = i;
        check("b2b C", C, 16'h8787);
        check("b2b borrow", borrow, 0);
      end else if (dones > 0) begin
        check("b2b C stable", C, 16'h8787);
      end
    end
    check("b2b done count", dones, 3);
    start = 1'b0;
    repeat (8) tick();
    check("b2b idle busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_subtraction_seq.md
Name: matrix_subtraction_seq

Overview:
- Sequential 2x2 matrix subtractor: C = A - B, element-wise.
- Counterpart to the combinational matrix adder.
- Uses the same flattened row-major operand bus format.
- Captures operands on a start pulse, computes one element per clock, then presents the result with a one-cycle done pulse and a per-element borrow vector.
- Sits in the bit-vector/matrix arithmetic group, driven by a controller or testbench sequencer.

Parameters:
- ELEM_W, 4, bit width of one matrix element.
- ROWS, 2, matrix rows.
- COLS, 2, matrix columns.
- Derived, not overridable: N = ROWS*COLS; BUS_W = N*ELEM_W (16 at defaults).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  [0:BUS_W-1]  minuend matrix, flattened.
- B  input  [0:BUS_W-1]  subtrahend matrix, flattened.
- C  output  [0:BUS_W-1]  difference matrix, registered.
- borrow  output  [0:N-1]  per-element underflow flags, registered.
- busy  output  1  high while computing.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Packing:
  - Element (r,c) has index k = r*COLS + c.
  - Element k occupies bus bits [k*ELEM_W : k*ELEM_W+ELEM_W-1] (ascending declaration), so (0,0) is leftmost.
  - borrow[k] corresponds to element k.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - C=0, borrow=0, busy=0, done=0.
  - Internal counters and operand registers are cleared.
- FSM states: IDLE, COMPUTE, DONE.
  - IDLE: on an edge with start=1, latch A and B into internal registers, set the element counter to 0, set busy=1, go to COMPUTE.
  - COMPUTE: each edge computes element counter k: diff = Areg[k] - Breg[k], modulo 2^ELEM_W. The borrow bit is 1 iff Areg[k] < Breg[k] (unsigned). Both are written to scratch registers and the counter increments. After the edge that processes k = N-1, go to DONE.
  - DONE: for exactly one cycle, transfer scratch to C and borrow, set done=1 and busy=0, then return to IDLE.
- Latency:
  - If start is sampled at edge 0, the outputs C, borrow and done change at edge N+1.
  - done is high for the single cycle following edge N+1.
  - At defaults: start edge 0 -> done visible after edge 5.
- Output stability:
  - C and borrow change only at the DONE transfer; they never expose partial results.
  - They hold their value until the next completed operation or reset.
- Boundary conditions:
  - start while busy (COMPUTE or DONE): ignored; no restart, no queueing.
  - start held continuously high: a new operation begins on the first IDLE edge, so back-to-back operations run every N+2 cycles.
  - A or B changing after capture: no effect on the operation in flight.
  - Reset mid-COMPUTE: the operation is aborted; no done pulse; outputs are cleared.
  - Equal elements: diff 0, borrow 0.
  - 0 - (2^ELEM_W - 1): diff 1, borrow 1.
- All arithmetic is unsigned; there is no saturation.

Test Plan:
- Basic subtraction: reset, then start with A=16'h9876, B=16'h1234 -> done pulse 5 cycles after the start edge, C=16'h8642, borrow=4'b0000, busy high for cycles 1-4.
- Full underflow: A=16'h0000, B=16'h1111 -> C=16'hFFFF, borrow=4'b1111.
- Mixed: A=16'h3A05, B=16'h5106 -> C=16'hE90F, borrow=4'b1001.
- Operand isolation and start-while-busy:
  - Start with A=16'hFFFF, B=16'h0000.
  - Change A to 16'h0000 on the next cycle and pulse start again during COMPUTE.
  - Required: exactly one done, C=16'hFFFF; the next done occurs only after a fresh start in IDLE.
- Reset mid-operation:
  - Assert rst two cycles after start.
  - Required: C=0, borrow=0, busy=0 immediately (asynchronous), no done pulse.
  - A subsequent start with A=16'h5555, B=16'h1111 yields C=16'h4444.
- Back-to-back:
  - Hold start=1 with A=16'h8888, B=16'h0101.
  - Required: done pulses every 6 cycles, C=16'h8787, borrow=4'b0000, C stable between pulses.
